// File: rtl/clock_countdown_pkg.sv
// Shared types and helpers for the BCD countdown timer.
// Contents:
//   state_e        - timer FSM states
//   BCD_NINE/FIVE  - digit wrap values
//   TIME_ZERO      - packed hh:mm:ss zero
//   bcd_time_valid - checks a packed hh:mm:ss BCD value against digit limits
package clock_pkg;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_e;

    localparam logic [3:0]  BCD_NINE  = 4'h9;
    localparam logic [3:0]  BCD_FIVE  = 4'h5;
    localparam logic [23:0] TIME_ZERO = 24'h000000;

    // t = {hh, mm, ss}, each byte {tens, ones}
    function automatic logic bcd_time_valid(input logic [23:0] t,
                                            input logic [3:0]  hh_tens_max);
        return (t[23:20] <= hh_tens_max) && (t[23:20] <= BCD_NINE) &&
               (t[19:16] <= BCD_NINE)    &&
               (t[15:12] <= BCD_FIVE)    && (t[11:8] <= BCD_NINE) &&
               (t[7:4]   <= BCD_FIVE)    && (t[3:0]  <= BCD_NINE);
    endfunction

endpackage

// File: rtl/clock_countdown_if.sv
// Request/status bundle for clock_countdown.
//   master: drives ena/load/load_*/start/pause, observes hh/mm/ss and flags
//   slave : the timer itself
interface clock_countdown_if;
    logic       ena;
    logic       load;
    logic [7:0] load_hh;
    logic [7:0] load_mm;
    logic [7:0] load_ss;
    logic       start;
    logic       pause;
    logic [7:0] hh;
    logic [7:0] mm;
    logic [7:0] ss;
    logic       running;
    logic       done;
    logic       expired;
    logic       load_err;

    modport master (
        output ena, load, load_hh, load_mm, load_ss, start, pause,
        input  hh, mm, ss, running, done, expired, load_err
    );

    modport slave (
        input  ena, load, load_hh, load_mm, load_ss, start, pause,
        output hh, mm, ss, running, done, expired, load_err
    );
endinterface

// File: rtl/clock_countdown_digit.sv
// One BCD down-counting digit.
//   clk, reset  - clock, async active-low reset (digit clears to 0)
//   dec_in      - decrement request (borrow from the lower digit)
//   load        - parallel load, overrides dec_in
//   load_val    - value for load
//   digit       - current digit
//   borrow_out  - dec_in while digit is 0; the digit wraps to MAX
module bcd_digit_down #(
    parameter logic [3:0] MAX = 4'h9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       dec_in,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic [3:0] digit,
    output logic       borrow_out
);

    logic [3:0] digit_q, digit_d;

    always_comb begin
        digit_d = digit_q;
        if (load)
            digit_d = load_val;
        else if (dec_in)
            digit_d = (digit_q == 4'h0) ? MAX : digit_q - 4'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) digit_q <= 4'h0;
        else        digit_q <= digit_d;
    end

    assign digit      = digit_q;
    assign borrow_out = dec_in & (digit_q == 4'h0);

endmodule

// File: rtl/clock_countdown.sv
// BCD hh:mm:ss countdown timer driven by a shared 1 Hz ena strobe.
//   clk, reset - clock, async active-low reset
//   bus        - clock_countdown_if.slave: ena/load/load_*/start/pause in,
//                hh/mm/ss, running, done (1-cycle expiry pulse),
//                expired (level), load_err (sticky) out
// Parameters:
//   AUTO_RELOAD - 1: reload last accepted value on expiry and keep running
//   HH_TENS_MAX - largest accepted hours tens digit
module clock_countdown
    import clock_pkg::*;
#(
    parameter bit         AUTO_RELOAD = 1'b0,
    parameter logic [3:0] HH_TENS_MAX = 4'h9
) (
    input  logic              clk,
    input  logic              reset,
    clock_countdown_if.slave  bus
);

    state_e          state_q, state_d;
    logic [23:0]     shadow_q, shadow_d;
    logic            done_q, done_d;
    logic            load_err_q, load_err_d;

    logic [5:0][3:0] dig;
    logic [6:0]      bor;
    logic [23:0]     time_w;
    logic [23:0]     load_w;
    logic            load_ok, load_bad;
    logic            time_zero, time_one;
    logic            tick, expire, reload;
    logic            dig_load;
    logic [23:0]     dig_val;
    logic            bor_unused;

    assign time_w    = dig;
    assign load_w    = {bus.load_hh, bus.load_mm, bus.load_ss};
    assign load_ok   = bus.load &  bcd_time_valid(load_w, HH_TENS_MAX);
    assign load_bad  = bus.load & ~bcd_time_valid(load_w, HH_TENS_MAX);
    assign time_zero = (time_w == TIME_ZERO);
    assign time_one  = (time_w == 24'h000001);

    // A pending load (even an invalid one) or pause blocks the decrement.
    assign tick   = (state_q == RUN) & bus.ena & ~bus.load & ~bus.pause;
    assign expire = tick & time_one;
    assign reload = expire & AUTO_RELOAD;

    // Auto-reload replaces the 00:00:01 -> 00:00:00 step with a shadow load,
    // so the outputs never show zero while running.
    assign dig_load = load_ok | reload;
    assign dig_val  = load_ok ? load_w : shadow_q;
    assign bor[0]   = tick & ~reload;

    for (genvar i = 0; i < 6; i++) begin : g_dig
        // digit order: ss ones, ss tens, mm ones, mm tens, hh ones, hh tens
        localparam logic [3:0] DMAX = (i == 1 || i == 3) ? BCD_FIVE : BCD_NINE;
        bcd_digit_down #(.MAX(DMAX)) u_dig (
            .clk        (clk),
            .reset      (reset),
            .dec_in     (bor[i]),
            .load       (dig_load),
            .load_val   (dig_val[i*4 +: 4]),
            .digit      (dig[i]),
            .borrow_out (bor[i+1])
        );
    end

    // hh tens only sees a borrow at 00:00:00, which is never decremented.
    assign bor_unused = bor[6];

    always_comb begin
        state_d    = state_q;
        shadow_d   = shadow_q;
        done_d     = expire;
        load_err_d = load_err_q;
        if (bus.load) begin
            if (load_ok) begin
                state_d    = IDLE;
                shadow_d   = load_w;
                load_err_d = 1'b0;
            end else begin
                load_err_d = 1'b1;
            end
        end else begin
            unique case (state_q)
                IDLE, PAUSE: if (bus.start && !time_zero) state_d = RUN;
                RUN: begin
                    if (bus.pause)                 state_d = PAUSE;
                    else if (expire && !AUTO_RELOAD) state_d = EXPIRED;
                end
                EXPIRED: state_d = EXPIRED;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            shadow_q   <= TIME_ZERO;
            done_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            done_q     <= done_d;
            load_err_q <= load_err_d;
        end
    end

    assign bus.hh       = time_w[23:16];
    assign bus.mm       = time_w[15:8];
    assign bus.ss       = time_w[7:0];
    assign bus.running  = (state_q == RUN);
    assign bus.expired  = (state_q == EXPIRED);
    assign bus.done     = done_q;
    assign bus.load_err = load_err_q;

endmodule

// File: tb/tb_clock_countdown.sv
// Self-checking bench for clock_countdown. Two instances share one stimulus
// stream: dut0 with AUTO_RELOAD=0 (bus b0), dut1 with AUTO_RELOAD=1 (bus b1).
module tb_clock_countdown;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    clock_countdown_if b0();
    clock_countdown_if b1();

    assign b1.ena     = b0.ena;
    assign b1.load    = b0.load;
    assign b1.load_hh = b0.load_hh;
    assign b1.load_mm = b0.load_mm;
    assign b1.load_ss = b0.load_ss;
    assign b1.start   = b0.start;
    assign b1.pause   = b0.pause;

    clock_countdown #(.AUTO_RELOAD(1'b0), .HH_TENS_MAX(4'h9)) dut0 (
        .clk(clk), .reset(reset), .bus(b0));
    clock_countdown #(.AUTO_RELOAD(1'b1), .HH_TENS_MAX(4'h9)) dut1 (
        .clk(clk), .reset(reset), .bus(b1));

    int checks   = 0;
    int failures = 0;
    logic [23:0] exp_q[$];
    logic [23:0] cur;

    // Reference model: go through plain seconds rather than digit borrows.
    function automatic int to_sec(input logic [23:0] t);
        return (int'(t[23:20]) * 10 + int'(t[19:16])) * 3600 +
               (int'(t[15:12]) * 10 + int'(t[11:8]))  * 60 +
                int'(t[7:4])   * 10 + int'(t[3:0]);
    endfunction

    function automatic logic [23:0] to_bcd(input int s);
        int h, m, x;
        h = s / 3600;
        m = (s % 3600) / 60;
        x = s % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10),
                4'(x / 10), 4'(x % 10)};
    endfunction

    function automatic logic [23:0] dec_model(input logic [23:0] t);
        return to_bcd(to_sec(t) - 1);
    endfunction

    task automatic do_cycle(input logic e, input logic l, input logic s,
                            input logic p, input logic [23:0] v);
        b0.ena = e; b0.load = l; b0.start = s; b0.pause = p;
        {b0.load_hh, b0.load_mm, b0.load_ss} = v;
        @(posedge clk);
        #1;
        b0.ena = 1'b0; b0.load = 1'b0; b0.start = 1'b0; b0.pause = 1'b0;
    endtask

    task automatic test_reset;
        logic [23:0] got;
        reset = 1'b0;
        do_cycle(0, 0, 0, 0, 24'h0);
        checks++;
        if ({b0.hh, b0.mm, b0.ss, b0.running, b0.done, b0.expired, b0.load_err} !== 28'h0) begin
            failures++;
            $display("FAIL reset_state got=%h exp=0", {b0.hh, b0.mm, b0.ss, b0.running, b0.done, b0.expired, b0.load_err});
        end
        #2 reset = 1'b1;
        do_cycle(0, 1, 0, 0, 24'h000040);
        cur = 24'h000040;
        do_cycle(0, 0, 1, 0, 24'h0);
        for (int i = 0; i < 3; i++) begin
            cur = dec_model(cur);
            exp_q.push_back(cur);
            do_cycle(1, 0, 0, 0, 24'h0);
            got = exp_q.pop_front();
            checks++;
            if ({b0.hh, b0.mm, b0.ss} !== got) begin
                failures++;
                $display("FAIL reset_precount got=%h exp=%h", {b0.hh, b0.mm, b0.ss}, got);
            end
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({b0.hh, b0.mm, b0.ss, b0.running, b0.done, b0.expired} !== 27'h0) begin
            failures++;
            $display("FAIL reset_async got=%h exp=0", {b0.hh, b0.mm, b0.ss, b0.running, b0.done, b0.expired});
        end
        #2 reset = 1'b1;
        do_cycle(0, 0, 1, 0, 24'h0);
        checks++;
        if ({b0.running, b0.hh, b0.mm, b0.ss} !== 25'h0) begin
            failures++;
            $display("FAIL reset_start_zero got=%h exp=0", {b0.running, b0.hh, b0.mm, b0.ss});
        end
    endtask

    task automatic test_countdown;
        logic [23:0] got;
        do_cycle(0, 1, 0, 0, 24'h000100);
        cur = 24'h000100;
        do_cycle(0, 0, 1, 0, 24'h0);
        for (int i = 0; i < 60; i++) begin
            cur = dec_model(cur);
            exp_q.push_back(cur);
            do_cycle(1, 0, 0, 0, 24'h0);
            got = exp_q.pop_front();
            checks++;
            if ({b0.hh, b0.mm, b0.ss} !== got) begin
                failures++;
                $display("FAIL count_val[%0d] got=%h exp=%h", i, {b0.hh, b0.mm, b0.ss}, got);
            end
            checks++;
            if ({b0.done, b0.expired, b0.running} !== ((i == 59) ? 3'b110 : 3'b001)) begin
                failures++;
                $display("FAIL count_flags[%0d] got=%b exp=%b", i, {b0.done, b0.expired, b0.running},
                         (i == 59) ? 3'b110 : 3'b001);
            end
        end
        do_cycle(0, 0, 0, 0, 24'h0);
        checks++;
        if ({b0.done, b0.expired} !== 2'b01) begin
            failures++;
            $display("FAIL done_one_cycle got=%b exp=01", {b0.done, b0.expired});
        end
        do_cycle(1, 0, 0, 0, 24'h0);
        checks++;
        if ({b0.hh, b0.mm, b0.ss, b0.expired, b0.done} !== 26'b10) begin
            failures++;
            $display("FAIL expired_hold got=%h exp=2", {b0.hh, b0.mm, b0.ss, b0.expired, b0.done});
        end
    endtask

    task automatic test_pause;
        logic [23:0] got;
        do_cycle(0, 1, 0, 0, 24'h100000);
        cur = 24'h100000;
        do_cycle(0, 0, 1, 0, 24'h0);
        cur = dec_model(cur);
        exp_q.push_back(cur);
        do_cycle(1, 0, 0, 0, 24'h0);
        got = exp_q.pop_front();
        checks++;
        if ({b0.hh, b0.mm, b0.ss} !== got || got !== 24'h095959) begin
            failures++;
            $display("FAIL hour_borrow got=%h exp=095959", {b0.hh, b0.mm, b0.ss});
        end
        exp_q.push_back(cur);
        do_cycle(1, 0, 0, 1, 24'h0);
        got = exp_q.pop_front();
        checks++;
        if ({b0.hh, b0.mm, b0.ss, b0.running} !== {got, 1'b0}) begin
            failures++;
            $display("FAIL pause_wins got=%h exp=%h", {b0.hh, b0.mm, b0.ss, b0.running}, {got, 1'b0});
        end
        do_cycle(1, 0, 0, 0, 24'h0);
        checks++;
        if ({b0.hh, b0.mm, b0.ss} !== cur) begin
            failures++;
            $display("FAIL paused_ena got=%h exp=%h", {b0.hh, b0.mm, b0.ss}, cur);
        end
        do_cycle(0, 0, 1, 0, 24'h0);
        cur = dec_model(cur);
        exp_q.push_back(cur);
        do_cycle(1, 0, 0, 0, 24'h0);
        got = exp_q.pop_front();
        checks++;
        if ({b0.hh, b0.mm, b0.ss, b0.running} !== {got, 1'b1}) begin
            failures++;
            $display("FAIL resume got=%h exp=%h", {b0.hh, b0.mm, b0.ss, b0.running}, {got, 1'b1});
        end
    endtask

    task automatic test_load_err;
        do_cycle(0, 1, 0, 0, 24'h006000);
        checks++;
        if ({b0.load_err, b0.running, b0.hh, b0.mm, b0.ss} !== {2'b11, 24'h095958}) begin
            failures++;
            $display("FAIL bad_mm got=%h exp=%h", {b0.load_err, b0.running, b0.hh, b0.mm, b0.ss}, {2'b11, 24'h095958});
        end
        do_cycle(0, 1, 0, 0, 24'h00000A);
        checks++;
        if ({b0.load_err, b0.hh, b0.mm, b0.ss} !== {1'b1, 24'h095958}) begin
            failures++;
            $display("FAIL bad_nibble got=%h exp=%h", {b0.load_err, b0.hh, b0.mm, b0.ss}, {1'b1, 24'h095958});
        end
        do_cycle(0, 1, 0, 0, 24'h955959);
        checks++;
        if ({b0.load_err, b0.running, b0.hh, b0.mm, b0.ss} !== {2'b00, 24'h955959}) begin
            failures++;
            $display("FAIL max_load got=%h exp=%h", {b0.load_err, b0.running, b0.hh, b0.mm, b0.ss}, {2'b00, 24'h955959});
        end
        do_cycle(0, 1, 0, 0, 24'h000060);
        do_cycle(0, 1, 0, 0, 24'h000005);
        checks++;
        if ({b0.load_err, b0.hh, b0.mm, b0.ss} !== {1'b0, 24'h000005}) begin
            failures++;
            $display("FAIL good_load got=%h exp=%h", {b0.load_err, b0.hh, b0.mm, b0.ss}, {1'b0, 24'h000005});
        end
    endtask

    task automatic test_auto_reload;
        logic [23:0] got;
        logic [23:0] shadow;
        shadow = 24'h000002;
        do_cycle(0, 1, 0, 0, shadow);
        cur = shadow;
        do_cycle(0, 0, 1, 0, 24'h0);
        for (int i = 0; i < 3; i++) begin
            cur = dec_model(cur);
            if (cur == 24'h0) cur = shadow;
            exp_q.push_back(cur);
            do_cycle(1, 0, 0, 0, 24'h0);
            got = exp_q.pop_front();
            checks++;
            if ({b1.hh, b1.mm, b1.ss, b1.done, b1.running, b1.expired} !== {got, (i == 1), 2'b10}) begin
                failures++;
                $display("FAIL auto_reload[%0d] got=%h exp=%h", i,
                         {b1.hh, b1.mm, b1.ss, b1.done, b1.running, b1.expired}, {got, (i == 1), 2'b10});
            end
            if (i == 1) begin
                checks++;
                if ({b0.done, b0.expired, b0.hh, b0.mm, b0.ss} !== {2'b11, 24'h0}) begin
                    failures++;
                    $display("FAIL no_reload got=%h exp=%h", {b0.done, b0.expired, b0.hh, b0.mm, b0.ss}, {2'b11, 24'h0});
                end
            end
        end
    endtask

    task automatic test_expired_load;
        do_cycle(1, 0, 1, 1, 24'h0);
        checks++;
        if ({b0.expired, b0.running, b0.hh, b0.mm, b0.ss} !== {2'b10, 24'h0}) begin
            failures++;
            $display("FAIL expired_ignore got=%h exp=%h", {b0.expired, b0.running, b0.hh, b0.mm, b0.ss}, {2'b10, 24'h0});
        end
        do_cycle(0, 1, 1, 0, 24'h001234);
        checks++;
        if ({b0.expired, b0.running, b0.hh, b0.mm, b0.ss} !== {2'b00, 24'h001234}) begin
            failures++;
            $display("FAIL load_over_start got=%h exp=%h", {b0.expired, b0.running, b0.hh, b0.mm, b0.ss}, {2'b00, 24'h001234});
        end
        do_cycle(0, 0, 1, 0, 24'h0);
        checks++;
        if (b0.running !== 1'b1) begin
            failures++;
            $display("FAIL restart got=%b exp=1", b0.running);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        b0.ena = 1'b0; b0.load = 1'b0; b0.start = 1'b0; b0.pause = 1'b0;
        b0.load_hh = 8'h0; b0.load_mm = 8'h0; b0.load_ss = 8'h0;
        reset = 1'b0;
        cur = 24'h0;
        test_reset();
        test_countdown();
        test_pause();
        test_load_err();
        test_auto_reload();
        test_expired_load();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
